// File: rtl/axi_perf_pkg.sv
// axi_perf_pkg: shared constants for the AXI performance monitor.
// Counter index map and AXI response codes.
package axi_perf_pkg;

  localparam int NUM_CNT  = 16;
  localparam int NUM_LIVE = NUM_CNT - 1;

  localparam int CNT_AW_XFER  = 0;
  localparam int CNT_AW_STALL = 1;
  localparam int CNT_W_XFER   = 2;
  localparam int CNT_W_STALL  = 3;
  localparam int CNT_B_XFER   = 4;
  localparam int CNT_B_STALL  = 5;
  localparam int CNT_AR_XFER  = 6;
  localparam int CNT_AR_STALL = 7;
  localparam int CNT_R_XFER   = 8;
  localparam int CNT_R_STALL  = 9;
  localparam int CNT_W_BURST  = 10;
  localparam int CNT_R_BURST  = 11;
  localparam int CNT_B_ERR    = 12;
  localparam int CNT_R_ERR    = 13;
  localparam int CNT_WIN_CYC  = 14;
  localparam int CNT_ZERO     = 15;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

endpackage

// File: rtl/axi_perf_monitor_counter.sv
// perf_counter: one live event counter plus its snapshot shadow.
// clear beats snap beats increment; ovf_pulse flags a lost count.
module perf_counter #(
  parameter int CNT_W         = 32,
  parameter bit SATURATE      = 1'b1,
  parameter bit CLEAR_ON_SNAP = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clear_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] shadow_o,
  output logic             ovf_pulse_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] bumped;
  logic             at_max;

  assign at_max = &cnt_q;

  // Increment with saturate-or-wrap at all-ones.
  always_comb begin
    bumped = cnt_q;
    if (inc_i) begin
      if (at_max) bumped = SATURATE ? cnt_q : '0;
      else        bumped = cnt_q + CNT_W'(1);
    end
  end

  // Resolve clear/snap/increment into next live and shadow values.
  always_comb begin
    cnt_d       = bumped;
    shadow_d    = shadow_q;
    ovf_pulse_o = inc_i & at_max;
    if (clear_i) begin
      cnt_d       = '0;
      ovf_pulse_o = 1'b0;
    end else if (snap_i) begin
      shadow_d = cnt_q;
      if (CLEAR_ON_SNAP) begin
        cnt_d       = CNT_W'(inc_i);
        ovf_pulse_o = 1'b0;
      end
    end
  end

  // Live and shadow registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign shadow_o = shadow_q;

endmodule

// File: rtl/axi_perf_monitor.sv
// axi_perf_monitor: passive AXI4 link monitor with snapshot counters.
// Decodes channel events, runs the window timer, read mux and LED hold.
module axi_perf_monitor
  import axi_perf_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter bit SATURATE      = 1'b1,
  parameter bit CLEAR_ON_SNAP = 1'b1,
  parameter int WINDOW_CYCLES = 0,
  parameter int ACT_HOLD      = 1024
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             AWVALID,
  input  logic             AWREADY,
  input  logic             WVALID,
  input  logic             WREADY,
  input  logic             WLAST,
  input  logic             BVALID,
  input  logic             BREADY,
  input  logic [1:0]       BRESP,
  input  logic             ARVALID,
  input  logic             ARREADY,
  input  logic             RVALID,
  input  logic             RREADY,
  input  logic             RLAST,
  input  logic [1:0]       RRESP,
  input  logic             enable,
  input  logic             clear,
  input  logic             snap,
  input  logic [3:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             snap_valid,
  output logic             ovf,
  output logic             active
);

  localparam int HOLD_W = (ACT_HOLD > 1) ? $clog2(ACT_HOLD) : 1;
  localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  logic [NUM_LIVE-1:0]             ev, inc, ovf_pulse;
  logic [NUM_CNT-1:0][CNT_W-1:0]   shadow;
  logic                            hs, auto_snap, snap_int;
  logic [WIN_W-1:0]                win_q, win_d;
  logic [HOLD_W-1:0]               hold_q, hold_d;
  logic [CNT_W-1:0]                rd_data_q;
  logic                            snap_valid_q, ovf_q, ovf_d;
  logic                            active_q, active_d;

  // Per-channel event decode; enable gates counting only.
  always_comb begin
    ev               = '0;
    ev[CNT_AW_XFER]  = AWVALID & AWREADY;
    ev[CNT_AW_STALL] = AWVALID & ~AWREADY;
    ev[CNT_W_XFER]   = WVALID & WREADY;
    ev[CNT_W_STALL]  = WVALID & ~WREADY;
    ev[CNT_B_XFER]   = BVALID & BREADY;
    ev[CNT_B_STALL]  = BVALID & ~BREADY;
    ev[CNT_AR_XFER]  = ARVALID & ARREADY;
    ev[CNT_AR_STALL] = ARVALID & ~ARREADY;
    ev[CNT_R_XFER]   = RVALID & RREADY;
    ev[CNT_R_STALL]  = RVALID & ~RREADY;
    ev[CNT_W_BURST]  = WVALID & WREADY & WLAST;
    ev[CNT_R_BURST]  = RVALID & RREADY & RLAST;
    ev[CNT_B_ERR]    = BVALID & BREADY &
                       ((BRESP == SLVERR) | (BRESP == DECERR));
    ev[CNT_R_ERR]    = RVALID & RREADY &
                       ((RRESP == SLVERR) | (RRESP == DECERR));
    ev[CNT_WIN_CYC]  = 1'b1;
    inc              = ev & {NUM_LIVE{enable}};
  end

  assign hs = ev[CNT_AW_XFER] | ev[CNT_W_XFER] | ev[CNT_B_XFER] |
              ev[CNT_AR_XFER] | ev[CNT_R_XFER];

  // Window timer and snapshot arbitration; clear wins over any snap.
  always_comb begin
    auto_snap = 1'b0;
    if (WINDOW_CYCLES > 0)
      auto_snap = enable & (win_q == WIN_W'(WINDOW_CYCLES - 1));
    snap_int = (snap | auto_snap) & ~clear;
    win_d    = win_q;
    if (clear || snap_int)
      win_d = '0;
    else if (enable && (WINDOW_CYCLES > 0))
      win_d = win_q + WIN_W'(1);
  end

  for (genvar i = 0; i < NUM_LIVE; i++) begin : g_cnt
    perf_counter #(
      .CNT_W        (CNT_W),
      .SATURATE     (SATURATE),
      .CLEAR_ON_SNAP(CLEAR_ON_SNAP)
    ) u_cnt (
      .clk_i      (ACLK),
      .rst_ni     (ARESETN),
      .inc_i      (inc[i]),
      .clear_i    (clear),
      .snap_i     (snap_int),
      .shadow_o   (shadow[i]),
      .ovf_pulse_o(ovf_pulse[i])
    );
  end

  assign shadow[CNT_ZERO] = '0;

  // Activity hold timer, sticky overflow flag and LED drive.
  always_comb begin
    hold_d = hold_q;
    if (hs)
      hold_d = HOLD_W'(ACT_HOLD - 1);
    else if (hold_q != '0)
      hold_d = hold_q - HOLD_W'(1);
    active_d = hs | (hold_q != '0);
    ovf_d    = ~clear & (ovf_q | (|ovf_pulse));
  end

  // Output and control-state registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      win_q        <= '0;
      hold_q       <= '0;
      active_q     <= 1'b0;
      ovf_q        <= 1'b0;
      snap_valid_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      win_q        <= win_d;
      hold_q       <= hold_d;
      active_q     <= active_d;
      ovf_q        <= ovf_d;
      snap_valid_q <= snap_int;
      rd_data_q    <= shadow[rd_sel];
    end
  end

  assign rd_data    = rd_data_q;
  assign snap_valid = snap_valid_q;
  assign ovf        = ovf_q;
  assign active     = active_q;

endmodule

// File: tb/tb_axi_perf_monitor.sv
// tb_axi_perf_monitor: three monitor configurations against a
// cycle-level arithmetic model, directed steps then random traffic.
module tb_axi_perf_monitor;
  import axi_perf_pkg::*;

  localparam int NI = 3;

  logic ACLK = 1'b0;
  logic ARESETN;
  logic AWVALID, AWREADY, WVALID, WREADY, WLAST;
  logic BVALID, BREADY, ARVALID, ARREADY;
  logic RVALID, RREADY, RLAST;
  logic [1:0] BRESP, RRESP;
  logic enable, clear, snap;
  logic [3:0] rd_sel;
  logic [7:0]  rd_a;
  logic [15:0] rd_b;
  logic [7:0]  rd_c;
  logic [NI-1:0] sv, ov, ac;

  int vectors = 0;
  int miscompares = 0;

  longint unsigned live [NI][NUM_CNT];
  longint unsigned sh   [NI][NUM_CNT];
  int     win  [NI];
  bit     movf [NI];
  longint cyc = 0;
  longint last_hs = -1000000;

  always #5 ACLK = ~ACLK;

  axi_perf_monitor #(.CNT_W(8), .SATURATE(1'b1), .CLEAR_ON_SNAP(1'b1),
    .WINDOW_CYCLES(0), .ACT_HOLD(16)) dut_a (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RRESP(RRESP),
    .enable(enable), .clear(clear), .snap(snap), .rd_sel(rd_sel),
    .rd_data(rd_a), .snap_valid(sv[0]), .ovf(ov[0]), .active(ac[0]));

  axi_perf_monitor #(.CNT_W(16), .SATURATE(1'b0), .CLEAR_ON_SNAP(1'b1),
    .WINDOW_CYCLES(100), .ACT_HOLD(1024)) dut_b (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RRESP(RRESP),
    .enable(enable), .clear(clear), .snap(snap), .rd_sel(rd_sel),
    .rd_data(rd_b), .snap_valid(sv[1]), .ovf(ov[1]), .active(ac[1]));

  axi_perf_monitor #(.CNT_W(8), .SATURATE(1'b0), .CLEAR_ON_SNAP(1'b0),
    .WINDOW_CYCLES(0), .ACT_HOLD(1024)) dut_c (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RRESP(RRESP),
    .enable(enable), .clear(clear), .snap(snap), .rd_sel(rd_sel),
    .rd_data(rd_c), .snap_valid(sv[2]), .ovf(ov[2]), .active(ac[2]));

  function automatic int p_w(int i);
    return (i == 1) ? 16 : 8;
  endfunction
  function automatic bit p_sat(int i);
    return (i == 0);
  endfunction
  function automatic bit p_cos(int i);
    return (i != 2);
  endfunction
  function automatic int p_win(int i);
    return (i == 1) ? 100 : 0;
  endfunction
  function automatic int p_hold(int i);
    return (i == 0) ? 16 : 1024;
  endfunction
  function automatic logic [63:0] obs_rd(int i);
    case (i)
      0:       return {56'd0, rd_a};
      1:       return {48'd0, rd_b};
      default: return {56'd0, rd_c};
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        live[i][k] = 0;
        sh[i][k]   = 0;
      end
      win[i]  = 0;
      movf[i] = 0;
    end
    last_hs = -1000000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_axi();
    AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0; WLAST = 0;
    BVALID = 0; BREADY = 0; BRESP = OKAY;
    ARVALID = 0; ARREADY = 0;
    RVALID = 0; RREADY = 0; RLAST = 0; RRESP = OKAY;
  endtask

  // One clock: advance the model from the sampled inputs, then compare.
  task automatic tick();
    logic [NUM_CNT-1:0] ev;
    bit hs, sint, ovfev, e;
    longint unsigned mx;
    logic [63:0] exp_rd [NI];
    bit exp_sv [NI];
    ev = '0;
    ev[0]  = AWVALID && AWREADY;  ev[1] = AWVALID && !AWREADY;
    ev[2]  = WVALID && WREADY;    ev[3] = WVALID && !WREADY;
    ev[4]  = BVALID && BREADY;    ev[5] = BVALID && !BREADY;
    ev[6]  = ARVALID && ARREADY;  ev[7] = ARVALID && !ARREADY;
    ev[8]  = RVALID && RREADY;    ev[9] = RVALID && !RREADY;
    ev[10] = ev[2] && WLAST;      ev[11] = ev[8] && RLAST;
    ev[12] = ev[4] && (BRESP >= 2);
    ev[13] = ev[8] && (RRESP >= 2);
    ev[14] = 1'b1;
    hs = ev[0] || ev[2] || ev[4] || ev[6] || ev[8];
    @(posedge ACLK);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      exp_rd[i] = (rd_sel == 4'd15) ? 64'd0 : sh[i][rd_sel];
      exp_sv[i] = 0;
    end
    if (!ARESETN) begin
      model_reset();
      for (int i = 0; i < NI; i++) exp_rd[i] = 0;
    end else begin
      if (hs) last_hs = cyc;
      for (int i = 0; i < NI; i++) begin
        mx = (64'd1 << p_w(i)) - 64'd1;
        sint = !clear && (snap || (p_win(i) > 0 && enable &&
                                   win[i] == p_win(i) - 1));
        ovfev = 0;
        for (int k = 0; k < NUM_CNT - 1; k++) begin
          e = enable && ev[k];
          if (clear) live[i][k] = 0;
          else begin
            if (e && live[i][k] == mx && !(sint && p_cos(i))) ovfev = 1;
            if (sint) sh[i][k] = live[i][k];
            if (sint && p_cos(i)) live[i][k] = e;
            else if (e)
              live[i][k] = (live[i][k] == mx) ?
                           (p_sat(i) ? mx : 64'd0) : live[i][k] + 1;
          end
        end
        movf[i] = !clear && (movf[i] || ovfev);
        if (clear || sint) win[i] = 0;
        else if (enable && p_win(i) > 0) win[i]++;
        exp_sv[i] = sint;
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rd_data[%0d]", i), obs_rd(i), exp_rd[i]);
      check($sformatf("snap_valid[%0d]", i), 64'(sv[i]), 64'(exp_sv[i]));
      check($sformatf("ovf[%0d]", i), 64'(ov[i]), 64'(movf[i]));
      check($sformatf("active[%0d]", i), 64'(ac[i]),
            64'((cyc - last_hs) < p_hold(i)));
    end
  endtask

  task automatic pulse_snap();
    snap = 1; tick(); snap = 0;
  endtask

  initial begin
    int n;
    idle_axi();
    enable = 0; clear = 0; snap = 0; rd_sel = 0;
    ARESETN = 1;
    model_reset();
    #2 ARESETN = 0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_rd[%0d]", i), obs_rd(i), 64'd0);
      check($sformatf("rst_sv[%0d]", i), 64'(sv[i]), 64'd0);
      check($sformatf("rst_ovf[%0d]", i), 64'(ov[i]), 64'd0);
      check($sformatf("rst_act[%0d]", i), 64'(ac[i]), 64'd0);
    end
    repeat (3) tick();
    ARESETN = 1; enable = 1;
    tick();

    // 10 AW handshakes, each preceded by 3 stall cycles
    for (int j = 0; j < 10; j++) begin
      AWVALID = 1; AWREADY = 0;
      repeat (3) tick();
      AWREADY = 1; tick();
      AWVALID = 0; AWREADY = 0;
    end
    pulse_snap();
    check("aw_snap_valid", 64'(sv[0]), 64'd1);
    rd_sel = CNT_AW_XFER; tick();
    check("aw_xfer", 64'(rd_a), 64'd10);
    check("aw_snap_once", 64'(sv[0]), 64'd0);
    rd_sel = CNT_AW_STALL; tick();
    check("aw_stall", 64'(rd_a), 64'd30);

    // 4 read bursts of 8 beats, last burst all SLVERR
    for (int b = 0; b < 4; b++) begin
      for (int t = 0; t < 8; t++) begin
        RVALID = 1; RREADY = 1; RLAST = (t == 7);
        RRESP = (b == 3) ? SLVERR : OKAY;
        tick();
      end
    end
    idle_axi();
    pulse_snap();
    rd_sel = CNT_R_XFER;  tick(); check("r_xfer", 64'(rd_a), 64'd32);
    rd_sel = CNT_R_BURST; tick(); check("r_burst", 64'(rd_a), 64'd4);
    rd_sel = CNT_R_ERR;   tick(); check("r_err", 64'(rd_a), 64'd8);

    // 300 W beats: saturate on A, wrap on C
    clear = 1; tick(); clear = 0;
    WVALID = 1; WREADY = 1;
    repeat (300) tick();
    idle_axi();
    pulse_snap();
    rd_sel = CNT_W_XFER; tick();
    check("w_sat", 64'(rd_a), 64'd255);
    check("w_wrap", 64'(rd_c), 64'd44);
    check("ovf_sat", 64'(ov[0]), 64'd1);
    check("ovf_wrap", 64'(ov[2]), 64'd1);
    clear = 1; tick(); clear = 0;
    check("ovf_clr_a", 64'(ov[0]), 64'd0);
    check("ovf_clr_c", 64'(ov[2]), 64'd0);

    // window mode on B with continuous B handshakes
    clear = 1; tick(); clear = 0;
    BVALID = 1; BREADY = 1; rd_sel = CNT_B_XFER;
    n = 0;
    repeat (300) begin tick(); if (sv[1]) n++; end
    check("win_pulses", 64'(n), 64'd3);
    tick();
    check("win_b_xfer", 64'(rd_b), 64'd100);
    rd_sel = CNT_WIN_CYC; tick();
    check("win_cycles", 64'(rd_b), 64'd100);
    enable = 0;
    repeat (50) tick();
    enable = 1;
    repeat (150) tick();
    idle_axi();

    // same-cycle snap/clear/AR, then snap with AR
    rd_sel = CNT_AR_XFER;
    ARVALID = 1; ARREADY = 1; snap = 1; clear = 1; tick();
    check("clr_blocks_snap", 64'(sv[0]), 64'd0);
    clear = 0; tick();
    snap = 1; ARVALID = 0; ARREADY = 0; tick();
    snap = 0;
    check("snap_excl_beat", 64'(rd_a), 64'd0);
    tick();
    check("next_incl_beat", 64'(rd_a), 64'd1);

    // randomized traffic
    for (int r = 0; r < 2000; r++) begin
      AWVALID = 1'($urandom_range(0, 1)); AWREADY = 1'($urandom_range(0, 1));
      WVALID  = 1'($urandom_range(0, 1)); WREADY  = 1'($urandom_range(0, 1));
      WLAST   = 1'($urandom_range(0, 1));
      BVALID  = 1'($urandom_range(0, 1)); BREADY  = 1'($urandom_range(0, 1));
      BRESP   = 2'($urandom_range(0, 3));
      ARVALID = 1'($urandom_range(0, 1)); ARREADY = 1'($urandom_range(0, 1));
      RVALID  = 1'($urandom_range(0, 1)); RREADY  = 1'($urandom_range(0, 1));
      RLAST   = 1'($urandom_range(0, 1));
      RRESP   = 2'($urandom_range(0, 3));
      enable  = ($urandom_range(0, 9) != 0);
      clear   = ($urandom_range(0, 63) == 0);
      snap    = ($urandom_range(0, 31) == 0);
      rd_sel  = 4'($urandom_range(0, 15));
      tick();
    end
    idle_axi();
    enable = 1; clear = 0; snap = 0;

    // activity hold length on A
    repeat (30) tick();
    n = 0;
    AWVALID = 1; AWREADY = 1; tick();
    if (ac[0]) n++;
    idle_axi();
    repeat (25) begin tick(); if (ac[0]) n++; end
    check("active_len", 64'(n), 64'd16);

    // asynchronous reset during a hold
    ARVALID = 1; ARREADY = 1; tick();
    idle_axi();
    repeat (5) tick();
    ARESETN = 0;
    #1;
    check("async_act", 64'(ac), 64'd0);
    check("async_ovf", 64'(ov), 64'd0);
    check("async_sv", 64'(sv), 64'd0);
    check("async_rd_a", 64'(rd_a), 64'd0);
    model_reset();
    repeat (2) tick();
    ARESETN = 1;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_perf_monitor.md
Name: axi_perf_monitor

Overview:
Passive, parametrised AXI4 traffic monitor that taps all five channels of one master/slave link. It supersedes the ad-hoc AR/AW handshake and backpressure counters used to drive a board LED. It counts per-channel transfers, stall cycles, bursts and error responses. Counters are snapshotted manually or on a fixed cycle window into shadow registers, read through an indexed port, and it drives a held activity indicator.

Parameters:
CNT_W, 32, width of every counter and of rd_data (8..64)
SATURATE, 1, 1 = counters hold at all-ones; 0 = counters wrap to 0
CLEAR_ON_SNAP, 1, 1 = live counters restart from 0 at each snapshot; 0 = they keep accumulating
WINDOW_CYCLES, 0, 0 = manual snapshots only; N>0 = automatic snapshot every N enabled cycles
ACT_HOLD, 1024, number of cycles the active output stays high after the last handshake

Ports:
ACLK  in  1  monitor clock, same as the monitored AXI link
ARESETN  in  1  reset, asynchronous, active-low
AWVALID, AWREADY, WVALID, WREADY, WLAST  in  1 each  write-side taps
BVALID, BREADY  in  1 each  write-response taps
BRESP  in  2  write-response code
ARVALID, ARREADY, RVALID, RREADY, RLAST  in  1 each  read-side taps
RRESP  in  2  read-response code
enable  in  1  count enable; while low, all counters and the window timer are frozen
clear  in  1  single-cycle pulse; zeroes live counters, window timer and ovf
snap  in  1  single-cycle pulse; manual snapshot
rd_sel  in  4  shadow counter index
rd_data  out  CNT_W  registered shadow value at index rd_sel
snap_valid  out  1  one-cycle pulse, high the cycle after a snapshot is captured
ovf  out  1  sticky; set when any live counter saturates or wraps
active  out  1  activity indicator (LED)

Behaviour:
- Counter index map. Each counter adds 1 in a cycle when its condition holds:
  - 0 AW xfer: AWVALID&AWREADY. 1 AW stall: AWVALID&!AWREADY.
  - 2 W xfer, 3 W stall. 4 B xfer, 5 B stall.
  - 6 AR xfer, 7 AR stall. 8 R xfer, 9 R stall.
  - 10 W bursts: W xfer & WLAST. 11 R bursts: R xfer & RLAST.
  - 12 B errors: B xfer & BRESP[1]. 13 R errors: R xfer & RRESP[1], counted per beat.
  - 14 window cycles: +1 every enabled cycle. 15 constant 0.
- Increment is at most 1 per counter per cycle. Counters have no combinational path to outputs.
- Overflow:
  - SATURATE=1: a counter at 2^CNT_W-1 stays there.
  - SATURATE=0: it wraps to 0.
  - In both cases ovf is set the cycle after the event.
- Priority in one cycle: ARESETN low > clear > snap > increment.
  - clear with a pending event: counter becomes 0 and the event is dropped. A snap in the same cycle is ignored.
  - snap with a pending event: the shadow captures the pre-increment value.
    - CLEAR_ON_SNAP=1: live counter = that cycle's increment (0 or 1).
    - CLEAR_ON_SNAP=0: live counter = pre-increment value plus the increment.
- Window mode (WINDOW_CYCLES>0):
  - The window timer counts enabled cycles 0..WINDOW_CYCLES-1.
  - At WINDOW_CYCLES-1 an internal snapshot fires, identical to snap, and the timer returns to 0.
  - An external snap also resets the timer to 0.
  - A clear resets the timer and suppresses an automatic snapshot due in that cycle.
- Snapshot when enable is low: still allowed. Shadows copy the frozen values.
- snap_valid: registered, high exactly one cycle after each capture.
- rd_data: registered, 1-cycle latency from rd_sel. It reflects the shadows, so it is stable between snapshots. Reading is non-destructive.
- active: hold counter reloads to ACT_HOLD-1 on any AW/W/B/AR/R handshake and decrements to 0. active = hold counter != 0, registered. It goes high the cycle after the first handshake.
- Handshakes are counted even when enable is low? No: enable gates all counters except the active hold logic.
- Reset (asynchronous assert, synchronous deassert by upstream):
  - All live counters, shadows, window timer, ovf, snap_valid, rd_data and active are 0.
  - Reset mid-window discards partial counts.

Decomposition:
- Package axi_perf_pkg holds:
  - Counter index localparams (CNT_AW_XFER=0 … CNT_WIN_CYC=14) and NUM_CNT=16.
  - The AXI response code constants (OKAY, EXOKAY, SLVERR, DECERR).
- One sub-module, perf_counter, instantiated 15 times. It contains one live counter and one shadow register, with inputs inc, clear, snap and parameters CNT_W, SATURATE, CLEAR_ON_SNAP. It outputs shadow and ovf_pulse.
- The top level holds the event decode, window timer, read mux, active timer and ovf OR.

Test Plan:
- Reset, then 10 AW handshakes with AWREADY low for 3 cycles before each, then snap → rd_sel=0 gives 10, rd_sel=1 gives 30; snap_valid pulses once.
- 4 read bursts of 8 beats, the last burst with RRESP=SLVERR on every beat, then snap → idx 8 = 32, idx 11 = 4, idx 13 = 8.
- CNT_W=8, SATURATE=1, 300 W beats → idx 2 = 255, ovf = 1. With SATURATE=0 → idx 2 = 44, ovf = 1. Then clear → ovf = 0.
- WINDOW_CYCLES=100, continuous B handshakes → snap_valid every 100 cycles, idx 4 = 100 and idx 14 = 100 per window. enable low for 50 cycles stretches the next window by 50.
- snap, clear and an AR handshake in the same cycle → AR xfer live = 0 and shadows unchanged. snap plus an AR handshake in the same cycle → shadow excludes the beat and the next window includes it (CLEAR_ON_SNAP=1).
- ACT_HOLD=16, one handshake → active is high for exactly 16 cycles starting the next cycle. Assert ARESETN low mid-hold → active drops asynchronously.
